// File: rtl/data_memory_bhw.sv
// data_memory_bhw
//   Byte-addressable data memory for a single-cycle RV32I datapath.
//   Loads are combinational and stores commit on the rising clock edge.
//   After reset, a scrub engine writes INIT_VAL into every word, one word
//   per cycle. BUSY is high while the scrub runs.
//
//   state | meaning
//   IDLE  | scrub finished; user loads and stores are served
//   CLEAR | scrub running; writes INIT_VAL to mem[ptr] each cycle
//
// Ports
//   CLK      clock, all state updates on posedge
//   RST      synchronous active-low reset; starts a new scrub
//   WE       store enable
//   FUNCT3   RV32I access size/sign
//   A        byte address; wraps modulo 4*DEPTH_WORDS
//   WD       store data
//   RD       load data, combinational; 0 when busy, misaligned or illegal
//   MISALIGN half access with A[0]=1, or word access with A[1:0]!=0
//   ILLEGAL  FUNCT3 not valid for a load (WE=0) or a store (WE=1)
//   BUSY     registered scrub-in-progress flag
module data_memory_bhw #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] INIT_VAL    = 32'h0000_000A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        MISALIGN,
    output logic        ILLEGAL,
    output logic        BUSY
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic            busy_nxt;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   widx;
    logic [1:0]      lane;
    logic [31:0]     word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     rd_raw;
    logic [31:0]     wdata;
    logic [3:0]      be;
    logic            half_acc;
    logic            word_acc;
    logic            scrub_we;
    logic            store_ok;
    logic            unused_a;

    assign widx     = A[AW+1:2];
    assign lane     = A[1:0];
    assign unused_a = ^A[31:AW+2];

    // Access decode: 001/101 are half-word, 010 is word.
    assign half_acc = (FUNCT3[1:0] == 2'b01);
    assign word_acc = (FUNCT3 == 3'b010);
    assign MISALIGN = (half_acc & A[0]) | (word_acc & (A[1:0] != 2'b00));
    // Stores only accept 000/001/010; loads reject 011/110/111.
    assign ILLEGAL  = WE ? (FUNCT3[2] | (FUNCT3[1:0] == 2'b11))
                         : ((FUNCT3 == 3'b011) | (FUNCT3[2:1] == 2'b11));

    // Scrub FSM
    always_ff @(posedge CLK) begin
        state <= state_nxt;
        ptr   <= ptr_nxt;
        BUSY  <= busy_nxt;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = BUSY;
        if (!RST) begin
            state_nxt = CLEAR;
            ptr_nxt   = '0;
            busy_nxt  = 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == LAST) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Store lane steering: replicate narrow data so each lane sees its bytes.
    always_comb begin
        wdata = WD;
        be    = 4'b0000;
        case (FUNCT3)
            3'b000: begin
                wdata = {4{WD[7:0]}};
                be    = 4'b0001 << lane;
            end
            3'b001: begin
                wdata = {2{WD[15:0]}};
                be    = A[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: be = 4'b1111;
            default: ;
        endcase
    end

    assign scrub_we = RST & (state == CLEAR);
    assign store_ok = RST & WE & ~BUSY & ~MISALIGN & ~ILLEGAL;

    always_ff @(posedge CLK) begin
        if (scrub_we) begin
            mem[ptr] <= INIT_VAL;
        end else if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Load path
    assign word   = mem[widx];
    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = A[1] ? word[31:16] : word[15:0];

    always_comb begin
        rd_raw = '0;
        case (FUNCT3)
            3'b000:  rd_raw = {{24{byte_v[7]}}, byte_v};
            3'b001:  rd_raw = {{16{half_v[15]}}, half_v};
            3'b010:  rd_raw = word;
            3'b100:  rd_raw = {24'b0, byte_v};
            3'b101:  rd_raw = {16'b0, half_v};
            default: rd_raw = '0;
        endcase
    end

    assign RD = (BUSY | MISALIGN | ILLEGAL) ? 32'h0 : rd_raw;

endmodule

// File: tb/tb_data_memory_bhw.sv
module tb_data_memory_bhw;
    localparam int DEPTH = 256;
    localparam int NBYTES = 4 * DEPTH;
    localparam logic [31:0] INIT = 32'h0000_000A;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b010;
    logic [31:0] A = 32'h0;
    logic [31:0] WD = 32'h0;
    logic [31:0] RD;
    logic        MISALIGN, ILLEGAL, BUSY;

    int total = 0;
    int bad = 0;

    data_memory_bhw #(.DEPTH_WORDS(DEPTH), .INIT_VAL(INIT)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .FUNCT3(FUNCT3), .A(A), .WD(WD),
        .RD(RD), .MISALIGN(MISALIGN), .ILLEGAL(ILLEGAL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference model: a flat byte array, little-endian.
    logic [7:0] mb [NBYTES];
    int         scrub_left = 0;
    bit         mvalid = 0;

    function automatic bit m_ill(logic we, logic [2:0] f);
        if (we) return !(f == 3'd0 || f == 3'd1 || f == 3'd2);
        return (f == 3'd3 || f == 3'd6 || f == 3'd7);
    endfunction

    function automatic bit m_mis(logic [2:0] f, logic [31:0] a);
        if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) return 1;
        if (f == 3'd2 && (a % 4 != 0)) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_rd(logic we, logic [2:0] f, logic [31:0] a);
        int i;
        logic [31:0] v;
        i = int'(a % NBYTES);
        if (scrub_left > 0 || m_mis(f, a) || m_ill(we, f)) return 32'h0;
        case (f)
            3'd0: begin v = 32'(mb[i]); if (v >= 128) v = v - 256; end
            3'd4: v = 32'(mb[i]);
            3'd1: begin v = 32'(mb[i]) + 256 * 32'(mb[i+1]); if (v >= 32768) v = v - 65536; end
            3'd5: v = 32'(mb[i]) + 256 * 32'(mb[i+1]);
            3'd2: v = {mb[i+3], mb[i+2], mb[i+1], mb[i]};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge CLK) begin
        if (!RST) begin
            scrub_left <= DEPTH;
            mvalid <= 1;
        end else if (scrub_left > 0) begin
            scrub_left <= scrub_left - 1;
            if (scrub_left == 1) begin
                for (int j = 0; j < NBYTES; j++) mb[j] <= INIT[8*(j%4) +: 8];
            end
        end else if (WE && !m_ill(WE, FUNCT3) && !m_mis(FUNCT3, A)) begin
            int i;
            i = int'(A % NBYTES);
            mb[i] <= WD[7:0];
            if (FUNCT3 != 3'd0) mb[i+1] <= WD[15:8];
            if (FUNCT3 == 3'd2) begin
                mb[i+2] <= WD[23:16];
                mb[i+3] <= WD[31:24];
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        if (mvalid) begin
            chk("rd", RD, m_rd(WE, FUNCT3, A));
            chk("misalign", 32'(MISALIGN), 32'(m_mis(FUNCT3, A)));
            chk("illegal", 32'(ILLEGAL), 32'(m_ill(WE, FUNCT3)));
            chk("busy", 32'(BUSY), 32'(scrub_left > 0));
        end
    end

    task automatic step(logic we, logic [2:0] f, logic [31:0] a, logic [31:0] wd);
        WE = we; FUNCT3 = f; A = a; WD = wd;
        @(posedge CLK); #1;
    endtask

    task automatic load_chk(string name, logic [2:0] f, logic [31:0] a, logic [31:0] exp);
        WE = 0; FUNCT3 = f; A = a;
        #2;
        chk(name, RD, exp);
        @(posedge CLK); #1;
    endtask

    task automatic busy_len(string name, int exp);
        int n;
        n = 0;
        WE = 0;
        while (BUSY === 1'b1 && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    initial begin
        // 1 reset and scrub
        @(posedge CLK); #1;
        RST = 0;
        step(0, 3'd2, 32'h0, 32'h0);
        step(0, 3'd2, 32'h0, 32'h0);
        #1 chk("busy_in_reset", 32'(BUSY), 32'h1);
        chk("rd_in_reset", RD, 32'h0);
        RST = 1;
        busy_len("scrub_len", 256);
        load_chk("lw_14", 3'd2, 32'h14, 32'h0000_000A);
        load_chk("lw_3fc", 3'd2, 32'h3FC, 32'h0000_000A);

        // 2 word and byte stores
        step(1, 3'd2, 32'h20, 32'h8001_7FFF);
        step(1, 3'd0, 32'h21, 32'h0000_00AB);
        load_chk("lw_20", 3'd2, 32'h20, 32'h8001_ABFF);
        load_chk("lb_21", 3'd0, 32'h21, 32'hFFFF_FFAB);
        load_chk("lbu_21", 3'd4, 32'h21, 32'h0000_00AB);

        // 3 half stores
        step(1, 3'd1, 32'h42, 32'h1234_8765);
        load_chk("lh_42", 3'd1, 32'h42, 32'hFFFF_8765);
        load_chk("lhu_42", 3'd5, 32'h42, 32'h0000_8765);
        load_chk("lw_40", 3'd2, 32'h40, 32'h8765_000A);

        // 4 misaligned and illegal
        WE = 1; FUNCT3 = 3'd2; A = 32'h23; WD = 32'h1111_1111;
        #2 chk("sw_mis_flag", 32'(MISALIGN), 32'h1);
        chk("sw_mis_rd", RD, 32'h0);
        @(posedge CLK); #1;
        WE = 1; FUNCT3 = 3'd1; A = 32'h41; WD = 32'h2222_2222;
        #2 chk("sh_mis_flag", 32'(MISALIGN), 32'h1);
        @(posedge CLK); #1;
        WE = 1; FUNCT3 = 3'd4; A = 32'h40; WD = 32'h3333_3333;
        #2 chk("st_ill_flag", 32'(ILLEGAL), 32'h1);
        @(posedge CLK); #1;
        load_chk("lw_20_kept", 3'd2, 32'h20, 32'h8001_ABFF);
        load_chk("lw_40_kept", 3'd2, 32'h40, 32'h8765_000A);

        // 6 wrap-around
        step(1, 3'd2, 32'h400, 32'h5555_AAAA);
        load_chk("lw_0_wrap", 3'd2, 32'h0, 32'h5555_AAAA);

        // 5 busy blocking and reset mid-scrub
        RST = 0;
        step(0, 3'd2, 32'h0, 32'h0);
        RST = 1;
        step(1, 3'd2, 32'h0, 32'hDEAD_BEEF);
        repeat (98) step(0, 3'd2, 32'h0, 32'h0);
        RST = 0;
        step(0, 3'd2, 32'h0, 32'h0);
        RST = 1;
        busy_len("rescrub_len", 256);
        load_chk("lw_0_scrubbed", 3'd2, 32'h0, 32'h0000_000A);

        // Randomized traffic; the per-cycle compare checks every cycle.
        for (int k = 0; k < 4000; k++) begin
            logic [31:0] a;
            RST = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 3) == 0) a = $urandom();
            else a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 95));
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
